pipelined_control_unit: RTL and testbench

Parametrised, handshaked successor to the single-stage control unit. Decodes a 12-instruction opcode set, including load/store, branch, jump, immediate and multi-cycle MUL, into a registered control bundle. Flow control is valid/ready on both sides, with a synchronous flush for pipeline redirect. Sits between fetch and the execute stage of the core pipeline.

---
 rtl/cu_pkg.sv | 53 +++++
 rtl/cu_decoder.sv | 69 ++++++
 rtl/pipelined_control_unit.sv | 121 ++++++++++++
 tb/tb_pipelined_control_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the pipelined control unit.
//   opcode_e  - 4-bit base opcode encodings
//   alu_op_e  - 3-bit ALU operation encodings
//   ctrl_t    - packed control bundle carried to the execute stage
//   CTRL_NOP  - all-flags-clear bundle with alu_op=NOP
//   CTRL_MUL  - bundle emitted when a multi-cycle MUL completes
package cu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_ADDI  = 4'd6,
    OP_LOAD  = 4'd7,
    OP_STORE = 4'd8,
    OP_BEQ   = 4'd9,
    OP_JAL   = 4'd10,
    OP_MUL   = 4'd11
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_MUL = 3'd5,
    ALU_NOP = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                 alu_src: 1'b0, alu_op: ALU_NOP, branch: 1'b0,
                                 jump: 1'b0, illegal: 1'b0};

  localparam ctrl_t CTRL_MUL = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                                 alu_src: 1'b0, alu_op: ALU_MUL, branch: 1'b0,
                                 jump: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: purely combinational opcode -> control bundle decode.
//   opcode [OPCODE_W-1:0] in  - instruction opcode
//   ctrl   ctrl_t         out - decoded control bundle
// Configuration: CU_ILLEGAL_TRAP_EN defined marks illegal opcodes with
// ctrl.illegal=1; otherwise illegal opcodes decode exactly as NOP.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  logic hi_nonzero;

  if (OPCODE_W > 4) begin : g_hi
    assign hi_nonzero = |opcode[OPCODE_W-1:4];
  end else begin : g_no_hi
    assign hi_nonzero = 1'b0;
  end

  always_comb begin
    ctrl = CTRL_NOP;
    if (hi_nonzero) begin
`ifdef CU_ILLEGAL_TRAP_EN
      ctrl.illegal = 1'b1;
`endif
    end else begin
      case (opcode[3:0])
        OP_NOP: ;
        OP_ADD: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
        OP_SUB: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
        OP_AND: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
        OP_OR:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
        OP_XOR: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_XOR; end
        OP_ADDI: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        OP_LOAD: begin
          ctrl.reg_write = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        OP_STORE: begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        OP_BEQ: begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; end
        OP_JAL: begin
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        OP_MUL: ctrl = CTRL_MUL;
        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
          ctrl.illegal = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: handshaked decode stage between fetch and execute.
//   clk, rst_n (async, active-low)
//   in_valid/in_ready/opcode   - opcode handshake from fetch
//   flush                      - synchronous redirect; drops bundle, aborts MUL
//   out_valid/out_ready        - bundle handshake to execute
//   reg_write, mem_read, mem_write, alu_src, branch, jump, alu_op[2:0]
//   busy                       - multi-cycle MUL in progress
//   illegal                    - current bundle came from an illegal opcode
// Configuration: CU_ILLEGAL_TRAP_EN (see cu_decoder).
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                branch,
  output logic                jump,
  output logic [2:0]          alu_op,
  output logic                busy,
  output logic                illegal
);

  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

  typedef enum logic [0:0] {S_IDLE, S_MUL_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec, out_q;
  logic             accept, is_mul, mul_done;

  cu_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode (opcode),
    .ctrl   (dec)
  );

  assign is_mul   = (dec.alu_op == ALU_MUL);
  assign in_ready = !flush && (state_q == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == S_MUL_WAIT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_done = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && is_mul) begin
            state_d = S_MUL_WAIT;
            cnt_d   = MUL_LOAD;
          end
        end
        S_MUL_WAIT: begin
          if (cnt_q == '0) begin
            mul_done = 1'b1;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // out_valid is always 0 while a MUL is pending (acceptance required the
  // register to be empty or draining), so completion can load unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= CTRL_NOP;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      out_q     <= CTRL_MUL;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      out_q     <= dec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign reg_write = out_q.reg_write;
  assign mem_read  = out_q.mem_read;
  assign mem_write = out_q.mem_write;
  assign alu_src   = out_q.alu_src;
  assign branch    = out_q.branch;
  assign jump      = out_q.jump;
  assign alu_op    = out_q.alu_op;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] opcode;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic       reg_write, mem_read, mem_write, alu_src, branch, jump;
  logic [2:0] alu_op;
  logic       busy;
  logic       illegal;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] sb[$];

  pipelined_control_unit #(.OPCODE_W(5), .MUL_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_src   (alu_src),
    .branch    (branch),
    .jump      (jump),
    .alu_op    (alu_op),
    .busy      (busy),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Bundle packing: {reg_write, mem_read, mem_write, alu_src, branch, jump, illegal, alu_op}
  function automatic logic [9:0] e(input logic rw, input logic mr, input logic mw,
                                   input logic as, input logic br, input logic jp,
                                   input logic il, input logic [2:0] alu);
    return {rw, mr, mw, as, br, jp, il, alu};
  endfunction

  function automatic logic [9:0] act_bundle();
    return {reg_write, mem_read, mem_write, alu_src, branch, jump, illegal, alu_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every drained bundle must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_bundle", {22'd0, act_bundle()}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] exp_b;
        exp_b = sb.pop_front();
        chk("bundle", {22'd0, act_bundle()}, {22'd0, exp_b});
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [9:0] exp_b, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    opcode   = op;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp_b);
        @(posedge clk);
        #1;
        return;
      end
      waits++;
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3,
                         A_XOR = 3'd4, A_MUL = 3'd5, A_NOP = 3'd7;

  logic [9:0] nop_b, ill_b;
  int w;

  initial begin
    nop_b = e(0,0,0,0,0,0,0,A_NOP);
`ifdef CU_ILLEGAL_TRAP_EN
    ill_b = e(0,0,0,0,0,0,1,A_NOP);
`else
    ill_b = e(0,0,0,0,0,0,0,A_NOP);
`endif
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bundle", {22'd0, act_bundle()}, {22'd0, nop_b});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single ADD, latency 1
    send(5'd1, e(1,0,0,0,0,0,0,A_ADD), w);
    in_valid = 1'b0;
    chk("add_latency_valid", {31'd0, out_valid}, 32'd1);

    // Back-to-back LOAD, STORE, BEQ, JAL
    send(5'd7,  e(1,1,0,1,0,0,0,A_ADD), w); chk("b2b_load_wait",  w, 0);
    send(5'd8,  e(0,0,1,1,0,0,0,A_ADD), w); chk("b2b_store_wait", w, 0);
    send(5'd9,  e(0,0,0,0,1,0,0,A_SUB), w); chk("b2b_beq_wait",   w, 0);
    send(5'd10, e(1,0,0,0,0,1,0,A_ADD), w); chk("b2b_jal_wait",   w, 0);
    // Remaining single-cycle opcodes, including NOP producing a bundle
    send(5'd0, nop_b, w);
    send(5'd3, e(1,0,0,0,0,0,0,A_AND), w);
    send(5'd4, e(1,0,0,0,0,0,0,A_OR), w);
    send(5'd5, e(1,0,0,0,0,0,0,A_XOR), w);
    send(5'd6, e(1,0,0,1,0,0,0,A_ADD), w);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // MUL: busy/in_ready=0 for 3 cycles, bundle after the 3rd edge
    send(5'd11, e(1,0,0,0,0,0,0,A_MUL), w);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mul_busy", {31'd0, busy}, 32'd1);
      chk("mul_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mul_no_valid", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    chk("mul_done_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: ADD held for 3 cycles while SUB waits
    out_ready = 1'b0;
    send(5'd1, e(1,0,0,0,0,0,0,A_ADD), w);
    opcode = 5'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {22'd0, act_bundle()}, {22'd0, e(1,0,0,0,0,0,0,A_ADD)});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(5'd2, e(1,0,0,0,0,0,0,A_SUB), w);
    chk("bp_sub_wait", w, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Flush two cycles into a MUL
    send(5'd11, e(1,0,0,0,0,0,0,A_MUL), w);
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("flush_no_bundle", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Illegal opcodes: 13 and out-of-range 0x11
    send(5'd13, ill_b, w);
    send(5'h11, ill_b, w);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a MUL
    send(5'd11, e(1,0,0,0,0,0,0,A_MUL), w);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_bundle", {22'd0, act_bundle()}, {22'd0, nop_b});
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_bundle", {31'd0, out_valid}, 32'd0);

    // Final transaction after reset recovery
    @(posedge clk); #1;
    send(5'd8, e(0,0,1,1,0,0,0,A_ADD), w);
    in_valid = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
